// File: rtl/npu_dma_pkg.sv
// Shared types and defaults for the NPU DMA loader slice.
package npu_dma_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } dma_state_e;

  localparam int unsigned DMA_ADDR_STEP = 4;

endpackage

// File: rtl/npu_dma_fifo.sv
// Read-data FIFO for the DMA loader; the head word is visible without a pop.
module npu_dma_fifo #(
  parameter int unsigned DWidth = 32,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [DWidth-1:0]          wdata,
  input  logic                       pop,
  output logic [DWidth-1:0]          rdata,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty,
  output logic                       full
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [DWidth-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [AW:0]       count_q;
  logic              do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == (AW+1)'(DEPTH));
  assign count   = count_q;
  assign rdata   = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/npu_dma_loader.sv
// Copies a block of words from an OBI-style read port into consecutive NPU
// addresses, sharing the NPU port with a host master that always wins.
module npu_dma_loader
  import npu_dma_pkg::*;
#(
  parameter int unsigned DWidth     = 32,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned LEN_W      = 16,
  parameter int unsigned ADDR_STEP  = DMA_ADDR_STEP
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              host_cen_i,
  input  logic              host_wen_i,
  input  logic [DWidth-1:0] host_addr_i,
  input  logic [DWidth-1:0] host_wdata_i,
  output logic [DWidth-1:0] host_rdata_o,
  input  logic              dma_start_i,
  input  logic [DWidth-1:0] dma_src_i,
  input  logic [DWidth-1:0] dma_dst_i,
  input  logic [LEN_W-1:0]  dma_len_i,
  output logic              dma_busy_o,
  output logic              dma_done_o,
  output logic              mem_req_o,
  output logic [DWidth-1:0] mem_addr_o,
  input  logic              mem_gnt_i,
  input  logic              mem_rvalid_i,
  input  logic [DWidth-1:0] mem_rdata_i,
  output logic              npu_cen_o,
  output logic              npu_wen_o,
  output logic [DWidth-1:0] npu_addr_o,
  output logic [DWidth-1:0] npu_wdata_o,
  input  logic [DWidth-1:0] npu_rdata_i
);

  localparam int unsigned       CW      = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW:0]       DEPTH_C = (CW+1)'(FIFO_DEPTH);
  localparam logic [DWidth-1:0] STEP    = DWidth'(ADDR_STEP);

  dma_state_e        state_q, state_d;
  logic [DWidth-1:0] src_ptr_q, dst_ptr_q;
  logic [LEN_W-1:0]  len_q, issued_q, written_q;
  logic [CW-1:0]     outstanding_q, fifo_count;
  logic [CW:0]       credits_used;
  logic [DWidth-1:0] fifo_head;
  logic              fifo_empty, fifo_full;
  logic              active, start_ok, grant, push, pop;

  assign active       = (state_q == RUN) || (state_q == DRAIN);
  assign start_ok     = (state_q == IDLE) && dma_start_i;
  assign credits_used = {1'b0, outstanding_q} + {1'b0, fifo_count};

  // Credits count words in flight plus words buffered, so a request is only
  // raised when its response is guaranteed a FIFO slot.
  assign mem_req_o  = (state_q == RUN) && (issued_q < len_q) && (credits_used < DEPTH_C);
  assign mem_addr_o = src_ptr_q;
  assign grant      = mem_req_o && mem_gnt_i;
  assign push       = mem_rvalid_i && active && (outstanding_q != '0) && !fifo_full;
  assign pop        = active && !host_cen_i && !fifo_empty;

  assign host_rdata_o = npu_rdata_i;

  npu_dma_fifo #(
    .DWidth (DWidth),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk_i),
    .rst_n (rst_ni),
    .push  (push),
    .wdata (mem_rdata_i),
    .pop   (pop),
    .rdata (fifo_head),
    .count (fifo_count),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    dma_busy_o = 1'b0;
    dma_done_o = 1'b0;
    case (state_q)
      IDLE: begin
        if (dma_start_i) state_d = (dma_len_i == '0) ? DONE : RUN;
      end
      RUN: begin
        dma_busy_o = 1'b1;
        if (issued_q == len_q) state_d = DRAIN;
      end
      DRAIN: begin
        dma_busy_o = 1'b1;
        if (written_q == len_q) state_d = DONE;
      end
      DONE: begin
        dma_done_o = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      src_ptr_q     <= '0;
      dst_ptr_q     <= '0;
      len_q         <= '0;
      issued_q      <= '0;
      written_q     <= '0;
      outstanding_q <= '0;
    end else if (start_ok) begin
      src_ptr_q     <= dma_src_i;
      dst_ptr_q     <= dma_dst_i;
      len_q         <= dma_len_i;
      issued_q      <= '0;
      written_q     <= '0;
      outstanding_q <= '0;
    end else begin
      if (grant) begin
        src_ptr_q <= src_ptr_q + STEP;
        issued_q  <= issued_q + LEN_W'(1);
      end
      if (grant && !push)      outstanding_q <= outstanding_q + CW'(1);
      else if (!grant && push) outstanding_q <= outstanding_q - CW'(1);
      if (pop) begin
        dst_ptr_q <= dst_ptr_q + STEP;
        written_q <= written_q + LEN_W'(1);
      end
    end
  end

  always_comb begin
    npu_cen_o   = 1'b0;
    npu_wen_o   = 1'b0;
    npu_addr_o  = '0;
    npu_wdata_o = '0;
    if (host_cen_i) begin
      npu_cen_o   = 1'b1;
      npu_wen_o   = host_wen_i;
      npu_addr_o  = host_addr_i;
      npu_wdata_o = host_wdata_i;
    end else if (pop) begin
      npu_cen_o   = 1'b1;
      npu_wen_o   = 1'b1;
      npu_addr_o  = dst_ptr_q;
      npu_wdata_o = fifo_head;
    end
  end

endmodule

// File: tb/tb_npu_dma_loader.sv
// Self-checking bench for npu_dma_loader: mux table, directed sequences and
// randomized transfers scored against an expected-write queue.
module tb_npu_dma_loader;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        host_cen_i, host_wen_i;
  logic [31:0] host_addr_i, host_wdata_i, host_rdata_o;
  logic        dma_start_i;
  logic [31:0] dma_src_i, dma_dst_i;
  logic [15:0] dma_len_i;
  logic        dma_busy_o, dma_done_o;
  logic        mem_req_o, mem_gnt_i, mem_rvalid_i;
  logic [31:0] mem_addr_o, mem_rdata_i;
  logic        npu_cen_o, npu_wen_o;
  logic [31:0] npu_addr_o, npu_wdata_o, npu_rdata_i;

  always #5 clk_i = ~clk_i;

  npu_dma_loader #(
    .DWidth     (32),
    .FIFO_DEPTH (4),
    .LEN_W      (16),
    .ADDR_STEP  (4)
  ) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .host_cen_i   (host_cen_i),
    .host_wen_i   (host_wen_i),
    .host_addr_i  (host_addr_i),
    .host_wdata_i (host_wdata_i),
    .host_rdata_o (host_rdata_o),
    .dma_start_i  (dma_start_i),
    .dma_src_i    (dma_src_i),
    .dma_dst_i    (dma_dst_i),
    .dma_len_i    (dma_len_i),
    .dma_busy_o   (dma_busy_o),
    .dma_done_o   (dma_done_o),
    .mem_req_o    (mem_req_o),
    .mem_addr_o   (mem_addr_o),
    .mem_gnt_i    (mem_gnt_i),
    .mem_rvalid_i (mem_rvalid_i),
    .mem_rdata_i  (mem_rdata_i),
    .npu_cen_o    (npu_cen_o),
    .npu_wen_o    (npu_wen_o),
    .npu_addr_o   (npu_addr_o),
    .npu_wdata_o  (npu_wdata_o),
    .npu_rdata_i  (npu_rdata_i)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  typedef struct {
    logic        cen, wen;
    logic [31:0] addr, wdata, rdata;
    logic        exp_cen, exp_wen;
    logic [31:0] exp_addr, exp_wdata;
  } vec_t;

  int checks = 0, failures = 0;
  int cyc = 0;
  int n_grants = 0, n_writes = 0, n_done = 0;
  int gnt_pct = 100, lat_min = 1, lat_max = 1;
  logic        stray_en = 1'b0;
  logic [31:0] mem_xor = '0;

  wr_t         exp_q[$];
  int          wr_cyc[$];
  logic [31:0] rq_data[$];
  int          rq_due[$];
  int          last_due = 0, lat, due;
  wr_t         mon_w;
  logic        prev_req = 1'b0, prev_gnt = 1'b0, prev_done = 1'b0;
  logic [31:0] prev_addr = '0;
  vec_t        vt[6];

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ mem_xor;
  endfunction

  // Source memory: grants at a random rate, answers in order 1..lat_max cycles later.
  initial begin
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
    forever begin
      @(posedge clk_i);
      cyc++;
      if (mem_req_o && mem_gnt_i) begin
        lat = $urandom_range(lat_max, lat_min);
        due = cyc + lat - 1;
        if (due <= last_due) due = last_due + 1;
        last_due = due;
        rq_data.push_back(mem_word(mem_addr_o));
        rq_due.push_back(due);
        n_grants++;
      end
      #1;
      if (rq_due.size() > 0 && rq_due[0] <= cyc) begin
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = rq_data.pop_front();
        void'(rq_due.pop_front());
      end else if (stray_en) begin
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'hDEAD_0000 | 32'($urandom_range(255, 0));
      end else begin
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = $urandom;
      end
      mem_gnt_i = ($urandom_range(99, 0) < gnt_pct);
    end
  end

  // Port monitor and scoreboard, sampled mid-cycle.
  initial begin
    forever begin
      @(negedge clk_i);
      chk("host_rdata", host_rdata_o, npu_rdata_i);
      if (host_cen_i) begin
        chk("host_pass", {npu_cen_o, npu_wen_o, npu_addr_o, npu_wdata_o},
            {1'b1, host_wen_i, host_addr_i, host_wdata_i});
      end else if (npu_cen_o) begin
        chk("dma_wen", npu_wen_o, 1'b1);
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_write addr=%0h data=%0h at t=%0t", npu_addr_o, npu_wdata_o, $time);
        end else begin
          mon_w = exp_q.pop_front();
          chk("dma_addr", npu_addr_o, mon_w.addr);
          chk("dma_data", npu_wdata_o, mon_w.data);
        end
        n_writes++;
        wr_cyc.push_back(cyc);
      end else begin
        chk("npu_idle", {npu_wen_o, npu_addr_o, npu_wdata_o}, '0);
      end
      checks++;
      if (n_grants > n_writes + 4) begin
        failures++;
        $display("FAIL credit inflight=%0d limit=4", n_grants - n_writes);
      end
      if (dma_done_o) begin
        chk("done_width", prev_done, 1'b0);
        n_done++;
      end
      prev_done = dma_done_o;
      if (rst_ni && prev_req && !prev_gnt) begin
        chk("req_hold", mem_req_o, 1'b1);
        chk("addr_hold", mem_addr_o, prev_addr);
      end
      prev_req  = rst_ni && mem_req_o;
      prev_gnt  = mem_gnt_i;
      prev_addr = mem_addr_o;
    end
  end

  task automatic drive_host(input int mode, input int c);
    logic busy;
    busy = (mode == 1) ? (c >= 2 && c < 8) :
           (mode == 2) ? ($urandom_range(3, 0) == 0) : 1'b0;
    host_cen_i   = busy;
    host_wen_i   = 1'($urandom);
    host_addr_i  = $urandom;
    host_wdata_i = $urandom;
    npu_rdata_i  = $urandom;
  endtask

  task automatic clear_counts();
    n_grants = 0; n_writes = 0; n_done = 0;
    wr_cyc.delete();
  endtask

  task automatic start_xfer(input logic [31:0] s, input logic [31:0] d, input int n);
    clear_counts();
    for (int i = 0; i < n; i++)
      exp_q.push_back('{addr: d + 32'(i * 4), data: mem_word(s + 32'(i * 4))});
    dma_src_i = s; dma_dst_i = d; dma_len_i = 16'(n); dma_start_i = 1'b1;
    @(posedge clk_i); #1;
    dma_start_i = 1'b0;
    if (n == 0) begin
      chk("len0_done_next", dma_done_o, 1'b1);
      chk("len0_no_req", mem_req_o, 1'b0);
    end else begin
      chk("start_to_req", mem_req_o, 1'b1);
      chk("start_busy", dma_busy_o, 1'b1);
    end
  endtask

  task automatic wait_done(input int budget, input int mode);
    for (int c = 0; c < budget && n_done == 0; c++) begin
      @(posedge clk_i); #1;
      drive_host(mode, c);
    end
    host_cen_i = 1'b0;
    if (n_done == 0) begin
      checks++; failures++;
      $display("FAIL done_timeout budget=%0d writes=%0d", budget, n_writes);
    end
  endtask

  task automatic finish_checks(input int n);
    chk("done_count", n_done, 1);
    chk("write_count", n_writes, n);
    chk("exp_left", exp_q.size(), 0);
    chk("busy_after", dma_busy_o, 1'b0);
    chk("done_after", dma_done_o, 1'b0);
  endtask

  initial begin
    rst_ni = 1'b0;
    host_cen_i = 1'b0; host_wen_i = 1'b0; host_addr_i = 32'h1234_5678; host_wdata_i = 32'h9ABC_DEF0;
    npu_rdata_i = '0; dma_start_i = 1'b0; dma_src_i = '0; dma_dst_i = '0; dma_len_i = '0;
    #1;
    chk("rst_mem_req", mem_req_o, 1'b0);
    chk("rst_mem_addr", mem_addr_o, '0);
    chk("rst_busy", dma_busy_o, 1'b0);
    chk("rst_done", dma_done_o, 1'b0);
    chk("rst_npu", {npu_cen_o, npu_wen_o, npu_addr_o, npu_wdata_o}, '0);
    repeat (2) @(posedge clk_i);
    #1 rst_ni = 1'b1;
    @(posedge clk_i); #1;

    // Host/NPU mux while the DMA is idle.
    vt[0] = '{1'b1, 1'b1, 32'h0000_1000, 32'hCAFE_BABE, 32'h1111_1111, 1'b1, 1'b1, 32'h0000_1000, 32'hCAFE_BABE};
    vt[1] = '{1'b1, 1'b0, 32'h0000_2004, 32'h1234_5678, 32'h2222_2222, 1'b1, 1'b0, 32'h0000_2004, 32'h1234_5678};
    vt[2] = '{1'b0, 1'b1, 32'h0000_3008, 32'hFFFF_FFFF, 32'h3333_3333, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000};
    vt[3] = '{1'b0, 1'b0, 32'hFFFF_FFFC, 32'hA5A5_A5A5, 32'h4444_4444, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000};
    vt[4] = '{1'b1, 1'b1, 32'hFFFF_FFFC, 32'h0000_0000, 32'h5555_5555, 1'b1, 1'b1, 32'hFFFF_FFFC, 32'h0000_0000};
    vt[5] = '{1'b1, 1'b0, 32'h0000_0000, 32'hFFFF_FFFF, 32'h6666_6666, 1'b1, 1'b0, 32'h0000_0000, 32'hFFFF_FFFF};
    for (int i = 0; i < 6; i++) begin
      host_cen_i = vt[i].cen; host_wen_i = vt[i].wen; host_addr_i = vt[i].addr;
      host_wdata_i = vt[i].wdata; npu_rdata_i = vt[i].rdata;
      #1;
      chk("table_npu", {npu_cen_o, npu_wen_o, npu_addr_o, npu_wdata_o},
          {vt[i].exp_cen, vt[i].exp_wen, vt[i].exp_addr, vt[i].exp_wdata});
      chk("table_rdata", host_rdata_o, vt[i].rdata);
      @(posedge clk_i); #1;
    end
    host_cen_i = 1'b0;

    // Basic copy: one write per cycle once the pipeline fills.
    mem_xor = '0; gnt_pct = 100; lat_min = 1; lat_max = 1;
    start_xfer(32'h100, 32'h40, 8);
    wait_done(200, 0);
    finish_checks(8);
    for (int k = 1; k < wr_cyc.size(); k++)
      chk("throughput", wr_cyc[k] - wr_cyc[0], k);

    // Host holds the port for 6 cycles mid-stream.
    start_xfer(32'h100, 32'h40, 8);
    wait_done(200, 1);
    finish_checks(8);

    // Slow memory.
    mem_xor = 32'h5A5A_0000; gnt_pct = 50; lat_min = 1; lat_max = 5;
    start_xfer(32'h1000, 32'h2000, 20);
    wait_done(2000, 0);
    finish_checks(20);

    // len == 0.
    gnt_pct = 100; lat_max = 1;
    start_xfer(32'h400, 32'h500, 0);
    wait_done(20, 0);
    finish_checks(0);
    chk("len0_grants", n_grants, 0);

    // Start while busy, then a start aligned with the DONE cycle: both ignored.
    start_xfer(32'h200, 32'h80, 4);
    dma_src_i = 32'h900; dma_dst_i = 32'hC00; dma_len_i = 16'd7; dma_start_i = 1'b1;
    @(posedge clk_i); #1;
    dma_start_i = 1'b0;
    for (int c = 0; c < 200 && !dma_done_o; c++) begin
      @(posedge clk_i); #1;
    end
    chk("done_seen", dma_done_o, 1'b1);
    dma_src_i = 32'hA00; dma_len_i = 16'd3; dma_start_i = 1'b1;
    @(posedge clk_i); #1;
    dma_start_i = 1'b0;
    repeat (10) begin @(posedge clk_i); #1; end
    finish_checks(4);
    chk("ignored_starts_grants", n_grants, 4);

    // Reset after three writes of a ten-word transfer.
    lat_min = 3; lat_max = 5;
    start_xfer(32'h300, 32'h600, 10);
    for (int c = 0; c < 300 && n_writes < 3; c++) begin
      @(posedge clk_i); #1;
    end
    chk("pre_reset_writes", n_writes, 3);
    exp_q.delete();
    rst_ni = 1'b0;
    #1;
    chk("mid_rst_req", mem_req_o, 1'b0);
    chk("mid_rst_addr", mem_addr_o, '0);
    chk("mid_rst_busy", dma_busy_o, 1'b0);
    chk("mid_rst_done", dma_done_o, 1'b0);
    chk("mid_rst_npu", {npu_cen_o, npu_wen_o, npu_addr_o, npu_wdata_o}, '0);
    repeat (2) begin @(posedge clk_i); #1; end
    rst_ni = 1'b1;
    clear_counts();
    stray_en = 1'b1;
    repeat (4) begin @(posedge clk_i); #1; end
    stray_en = 1'b0;
    repeat (8) begin @(posedge clk_i); #1; end
    chk("stray_writes", n_writes, 0);
    chk("stray_grants", n_grants, 0);
    chk("stray_busy", dma_busy_o, 1'b0);
    lat_min = 1; lat_max = 1;
    start_xfer(32'h700, 32'h800, 2);
    wait_done(100, 0);
    finish_checks(2);

    // Randomized transfers with random host traffic.
    for (int t = 0; t < 6; t++) begin
      logic [31:0] s, d;
      int n;
      s = $urandom & ~32'h3;
      d = (t == 0) ? 32'hFFFF_FFF0 : ($urandom & ~32'h3);
      n = $urandom_range(20, 1);
      gnt_pct = $urandom_range(100, 40);
      lat_min = 1; lat_max = $urandom_range(5, 1);
      mem_xor = $urandom;
      start_xfer(s, d, n);
      wait_done(3000, 2);
      finish_checks(n);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #900_000;
    failures++;
    $display("FAIL watchdog time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
